// File: rtl/mem_stage_if.sv
// Execute-to-memory-stage bus with the write-back outputs of mem_stage.
// The master drives an EX result; the slave (mem_stage) returns WB data and stall.
interface mem_stage_if;
  // valid qualifies the EX inputs only while stall_flag is low. wb_valid
  // qualifies wb_* for exactly one cycle and has no back-pressure.
  logic        valid;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  address_in;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        stall_flag;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        wb_reg_write;
  logic        wb_valid;
  logic        misalign;
  logic        state_dbg;

  modport master (
    output valid, alu_result, store_data, address_in, mem_read, mem_write, reg_write,
    input  stall_flag, wb_data, wb_addr, wb_reg_write, wb_valid, misalign, state_dbg
  );

  modport slave (
    input  valid, alu_result, store_data, address_in, mem_read, mem_write, reg_write,
    output stall_flag, wb_data, wb_addr, wb_reg_write, wb_valid, misalign, state_dbg
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word load/store on internal RAM with MEM_LAT wait cycles.
// Optional MEM_MISALIGN_TRAP_EN: misaligned mem ops are flagged and suppressed.
module mem_stage #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  mem_stage_if.slave   bus
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state;
  logic [CNT_W-1:0]   counter;
  logic [31:0]        mem [DEPTH];

  logic               lat_store;
  logic               lat_rw;
  logic [31:0]        lat_alu;
  logic [31:0]        lat_data;
  logic [4:0]         lat_dest;

  logic               in_mem_op;
  logic               in_store;
  logic               in_rw;
  logic               in_mis;
  logic [ADDR_W-1:0]  in_idx;
  logic [ADDR_W-1:0]  lat_idx;
  logic               busy_done;

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_widx;
  logic [31:0]        mem_wdata;

  assign in_mem_op = bus.valid & (bus.mem_read | bus.mem_write);
  // A write request wins over a read when both are set.
  assign in_store  = bus.valid & bus.mem_write;
  assign in_rw     = bus.reg_write & (bus.address_in != 5'd0);
  assign in_idx    = bus.alu_result[ADDR_W+1:2];
  assign lat_idx   = lat_alu[ADDR_W+1:2];
  assign busy_done = (state == BUSY) && (counter == '0);

`ifdef MEM_MISALIGN_TRAP_EN
  assign in_mis = in_mem_op & (|bus.alu_result[1:0]);
`else
  assign in_mis = 1'b0;
`endif

  assign bus.state_dbg = logic'(state);

  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = in_idx;
    mem_wdata = bus.store_data;
    if (busy_done) begin
      mem_we    = lat_store;
      mem_widx  = lat_idx;
      mem_wdata = lat_data;
    end else if ((state == IDLE) && (MEM_LAT == 0)) begin
      mem_we    = in_store & ~in_mis;
    end
    // An access cut short by reset must never reach the RAM.
    mem_we = mem_we & reset;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      counter          <= '0;
      bus.stall_flag   <= 1'b0;
      bus.wb_data      <= '0;
      bus.wb_addr      <= '0;
      bus.wb_reg_write <= 1'b0;
      bus.wb_valid     <= 1'b0;
      bus.misalign     <= 1'b0;
      lat_store        <= 1'b0;
      lat_rw           <= 1'b0;
      lat_alu          <= '0;
      lat_data         <= '0;
      lat_dest         <= '0;
    end else begin
      bus.misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.valid) begin
            bus.wb_valid <= 1'b0;
          end else if (!in_mem_op || in_mis || (MEM_LAT == 0)) begin
            bus.wb_valid <= 1'b1;
            bus.wb_addr  <= bus.address_in;
            bus.misalign <= in_mis;
            if (in_mem_op && !in_store && !in_mis) begin
              bus.wb_data      <= mem[in_idx];
              bus.wb_reg_write <= in_rw;
            end else if (in_mem_op) begin
              bus.wb_data      <= bus.alu_result;
              bus.wb_reg_write <= 1'b0;
            end else begin
              bus.wb_data      <= bus.alu_result;
              bus.wb_reg_write <= in_rw;
            end
          end else begin
            lat_store      <= in_store;
            lat_rw         <= in_rw;
            lat_alu        <= bus.alu_result;
            lat_data       <= bus.store_data;
            lat_dest       <= bus.address_in;
            counter        <= CNT_W'(MEM_LAT - 1);
            state          <= BUSY;
            bus.stall_flag <= 1'b1;
            bus.wb_valid   <= 1'b0;
          end
        end
        BUSY: begin
          if (counter != '0) begin
            counter <= counter - 1'b1;
          end else begin
            bus.wb_valid   <= 1'b1;
            bus.wb_addr    <= lat_dest;
            bus.stall_flag <= 1'b0;
            state          <= IDLE;
            if (lat_store) begin
              bus.wb_data      <= lat_alu;
              bus.wb_reg_write <= 1'b0;
            end else begin
              bus.wb_data      <= mem[lat_idx];
              bus.wb_reg_write <= lat_rw;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage (default MEM_LAT=2); also covers MEM_MISALIGN_TRAP_EN builds.
module tb_mem_stage;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if bus();

  mem_stage #(.DEPTH(256), .ADDR_W(8), .MEM_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one instruction for a single accept edge, then counts stall cycles.
  task automatic issue(input logic rd, input logic wr, input logic rw, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [4:0] dst, output int stalls);
    @(negedge clk);
    bus.valid      = 1'b1;
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.reg_write  = rw;
    bus.alu_result = alu;
    bus.store_data = sd;
    bus.address_in = dst;
    @(posedge clk);
    @(negedge clk);
    bus.valid     = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    stalls = 0;
    while (bus.stall_flag === 1'b1 && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
  endtask

  task automatic check_wb(input string tag, input int stalls, input int exp_stalls,
                          input logic [4:0] exp_addr, input logic exp_rw);
    check_val({tag, ".stalls"}, 32'(stalls), 32'(exp_stalls));
    check_val({tag, ".valid"}, 32'(bus.wb_valid), 32'd1);
    check_val({tag, ".data"}, bus.wb_data, exp_q.pop_front());
    check_val({tag, ".addr"}, 32'(bus.wb_addr), 32'(exp_addr));
    check_val({tag, ".rw"}, 32'(bus.wb_reg_write), 32'(exp_rw));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    bus.valid = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.reg_write = 1'b0;
    bus.alu_result = '0; bus.store_data = '0; bus.address_in = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst.stall", 32'(bus.stall_flag), 32'd0);
    check_val("rst.valid", 32'(bus.wb_valid), 32'd0);
    check_val("rst.data", bus.wb_data, 32'd0);
    check_val("rst.addr", 32'(bus.wb_addr), 32'd0);
    check_val("rst.rw", 32'(bus.wb_reg_write), 32'd0);
    check_val("rst.mis", 32'(bus.misalign), 32'd0);
    check_val("rst.state", 32'(bus.state_dbg), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // ALU pass-through, then an idle cycle holds data and drops valid
    exp_q.push_back(32'h0000_0007);
    issue(1'b0, 1'b0, 1'b1, 32'h0000_0007, 32'h0, 5'd5, st);
    check_wb("alu", st, 0, 5'd5, 1'b1);
    @(negedge clk);
    check_val("idle.valid", 32'(bus.wb_valid), 32'd0);
    check_val("idle.data", bus.wb_data, 32'h0000_0007);

    // Store then load at 0x10
    exp_q.push_back(32'h0000_0010);
    issue(1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 5'd3, st);
    check_wb("sw10", st, LAT, 5'd3, 1'b0);
    exp_q.push_back(32'hDEAD_BEEF);
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 5'd8, st);
    check_wb("lw10", st, LAT, 5'd8, 1'b1);

    // Address wrap: 0x400 aliases word 0
    exp_q.push_back(32'h0000_0000);
    issue(1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_1234, 5'd2, st);
    check_wb("sw0", st, LAT, 5'd2, 1'b0);
    exp_q.push_back(32'h0000_1234);
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'h0, 5'd9, st);
    check_wb("lw400", st, LAT, 5'd9, 1'b1);

    // Reset during BUSY aborts the store to 0x20
    exp_q.push_back(32'h0000_0020);
    issue(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_5555, 5'd1, st);
    check_wb("sw20", st, LAT, 5'd1, 1'b0);
    @(negedge clk);
    bus.valid = 1'b1; bus.mem_write = 1'b1; bus.alu_result = 32'h20; bus.store_data = 32'hAAAA;
    bus.address_in = 5'd6;
    @(posedge clk);
    @(negedge clk);
    bus.valid = 1'b0; bus.mem_write = 1'b0;
    check_val("abort.busy", 32'(bus.stall_flag), 32'd1);
    reset = 1'b0;
    #1;
    check_val("abort.stall", 32'(bus.stall_flag), 32'd0);
    check_val("abort.valid", 32'(bus.wb_valid), 32'd0);
    check_val("abort.data", bus.wb_data, 32'd0);
    check_val("abort.state", 32'(bus.state_dbg), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.push_back(32'h0000_5555);
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h0, 5'd7, st);
    check_wb("lw20", st, LAT, 5'd7, 1'b1);

    // Destination $0 never written
    exp_q.push_back(32'hDEAD_BEEF);
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 5'd0, st);
    check_wb("lwr0", st, LAT, 5'd0, 1'b0);

    // Read+write together behaves as a store
    exp_q.push_back(32'h0000_0030);
    issue(1'b1, 1'b1, 1'b1, 32'h0000_0030, 32'h0000_CAFE, 5'd4, st);
    check_wb("rdwr", st, LAT, 5'd4, 1'b0);
    exp_q.push_back(32'h0000_CAFE);
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0030, 32'h0, 5'd10, st);
    check_wb("lw30", st, LAT, 5'd10, 1'b1);

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned store is trapped: flagged, no stall, no write
    issue(1'b0, 1'b1, 1'b1, 32'h0000_0013, 32'h0000_7777, 5'd11, st);
    check_val("mis.stalls", 32'(st), 32'd0);
    check_val("mis.flag", 32'(bus.misalign), 32'd1);
    check_val("mis.valid", 32'(bus.wb_valid), 32'd1);
    check_val("mis.rw", 32'(bus.wb_reg_write), 32'd0);
    @(negedge clk);
    check_val("mis.pulse", 32'(bus.misalign), 32'd0);
    exp_q.push_back(32'hDEAD_BEEF);
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 5'd12, st);
    check_wb("mis.lw10", st, LAT, 5'd12, 1'b1);
`else
    // Without the trap the low address bits are ignored
    exp_q.push_back(32'h0000_0013);
    issue(1'b0, 1'b1, 1'b1, 32'h0000_0013, 32'h0000_7777, 5'd11, st);
    check_wb("sw13", st, LAT, 5'd11, 1'b0);
    check_val("nomis.flag", 32'(bus.misalign), 32'd0);
    exp_q.push_back(32'h0000_7777);
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 5'd12, st);
    check_wb("nomis.lw10", st, LAT, 5'd12, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Captures the ALU result, store data and destination register, then performs a word load/store on an internal data memory.
- Presents registered write-back data to the WB stage.
- Models a configurable memory latency and raises stall_flag to freeze upstream stages while an access is in flight.

Parameters:
- DEPTH, 256, number of 32-bit words in data memory (power of two)
- ADDR_W, 8, log2(DEPTH); word index width
- MEM_LAT, 2, wait cycles per load/store (0 = single-cycle access)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- valid  input  1  EX result on inputs is a real instruction
- alu_result  input  32  byte address for load/store; result for ALU ops
- store_data  input  32  rt value written on a store
- address_in  input  5  destination register number
- mem_read  input  1  load
- mem_write  input  1  store
- reg_write  input  1  instruction writes the register file
- stall_flag  output  1  upstream must hold its outputs while high
- wb_data  output  32  load data or passed-through ALU result
- wb_addr  output  5  destination register for WB
- wb_reg_write  output  1  WB register-file write enable
- wb_valid  output  1  wb_* outputs carry a completed instruction
- misalign  output  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0.
  - stall_flag, wb_data, wb_addr, wb_reg_write, wb_valid and misalign all 0.
  - Memory contents are not cleared.
- Word index is alu_result[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- States are IDLE and BUSY. Inputs are sampled only in IDLE; in BUSY they are ignored.
- IDLE, valid=0: wb_valid<=0; wb_data, wb_addr and wb_reg_write hold.
- IDLE, valid=1, no mem op:
  - wb_data<=alu_result, wb_addr<=address_in.
  - wb_reg_write<=reg_write, wb_valid<=1.
  - Latency 1 cycle.
- IDLE, mem op, MEM_LAT=0:
  - Access completes at the same edge.
  - Load: wb_data<=mem[idx].
  - Store: mem[idx]<=store_data.
  - wb_valid<=1; no stall.
- IDLE, mem op, MEM_LAT>0:
  - Latch op, address, data and destination.
  - counter<=MEM_LAT-1, state<=BUSY, stall_flag<=1, wb_valid<=0.
- BUSY, counter!=0: counter decrements; stall_flag stays 1; wb_valid stays 0.
- BUSY, counter==0:
  - Perform the access; load wb_* outputs; wb_valid<=1.
  - stall_flag<=0, state<=IDLE.
  - stall_flag is therefore high for exactly MEM_LAT cycles. The result is visible MEM_LAT edges after the accept edge.
- Store: wb_reg_write forced 0; wb_data<=alu_result.
- Load: wb_reg_write<=reg_write.
- mem_read and mem_write both 1: treated as a store; no register write.
- address_in==0: wb_reg_write forced 0 (register $0 is never written).
- Back-to-back mem ops: the next op is accepted on the first IDLE edge after stall_flag falls. No op is dropped or duplicated.
- Reset asserted in BUSY: access aborted, no memory write, outputs cleared immediately.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - A mem op with alu_result[1:0]!=0 sets misalign<=1 for one cycle at the accept edge.
  - The access is suppressed: no write, wb_reg_write=0, wb_valid=1.
  - It completes in 1 cycle with no stall.
- Undefined:
  - alu_result[1:0] is ignored (access is word-aligned down).
  - misalign is tied to 0.

Test Plan:
- ALU pass-through: valid=1, alu_result=0x0000_0007, address_in=5, reg_write=1 -> next edge wb_data=7, wb_addr=5, wb_reg_write=1, wb_valid=1, stall_flag=0.
- Store then load, MEM_LAT=2:
  - sw store_data=0xDEAD_BEEF to address 0x10 -> stall_flag high 2 cycles, wb_reg_write=0.
  - lw 0x10 to address_in=8 -> after 2 stall cycles wb_data=0xDEADBEEF, wb_addr=8, wb_valid=1.
- Wrap-around: store 0x1234 to address 0x0 with DEPTH=256, then load 0x400 -> wb_data=0x1234.
- Reset mid-access: store 0xAAAA to 0x20, drop reset in the first BUSY cycle -> outputs 0 immediately; later load of 0x20 does not return 0xAAAA.
- Register-0 and priority: load with address_in=0 -> wb_reg_write=0; mem_read=mem_write=1 -> memory written, wb_reg_write=0.
- With MEM_MISALIGN_TRAP_EN: store to 0x13 -> misalign=1 for one cycle, memory word 0x10 unchanged, no stall.
